// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with target buffer for the IF stage.
// Combinational lookup on the fetch PC; EX resolution trains the table on the clock edge.
module branch_predictor_bht #(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 24,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        flush,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredict
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [31:0]        r_stat_branches;
  logic [31:0]        r_stat_mispredict;

  logic [IDX_W-1:0]   w_if_idx;
  logic [TAG_W-1:0]   w_if_tag;
  logic               w_if_hit;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic [1:0]         w_upd_cnt;
  logic [1:0]         w_cnt_nxt;
  logic               w_mispredict;

  assign w_if_idx  = if_pc[IDX_W+1:2];
  assign w_if_tag  = if_pc[31:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[31:IDX_W+2];

  // Lookup reads registered contents only, so a same-cycle update is not visible yet.
  assign w_if_hit    = r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit & r_cnt[w_if_idx][1];
  assign pred_target = pred_taken ? r_target[w_if_idx] : 32'h0;

  assign w_upd_hit    = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_cnt    = r_cnt[w_upd_idx];
  assign w_mispredict = upd_pred_taken ^ upd_taken;

  always_comb begin
    w_cnt_nxt = w_upd_cnt;
    if (upd_taken) begin
      if (w_upd_cnt != 2'b11) w_cnt_nxt = w_upd_cnt + 2'd1;
    end else begin
      if (w_upd_cnt != 2'b00) w_cnt_nxt = w_upd_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid           <= '0;
      r_stat_branches   <= '0;
      r_stat_mispredict <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b00;
    end else begin
      if (upd_valid) begin
        r_stat_branches <= r_stat_branches + 32'd1;
        if (w_mispredict) r_stat_mispredict <= r_stat_mispredict + 32'd1;
      end
      // Flush wins over the table write, but the branch was still resolved and counted above.
      if (flush) begin
        r_valid <= '0;
      end else if (upd_valid) begin
        if (w_upd_hit) begin
          r_cnt[w_upd_idx] <= w_cnt_nxt;
          if (upd_taken) r_target[w_upd_idx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_cnt[w_upd_idx]    <= CNT_INIT;
          r_target[w_upd_idx] <= upd_target;
        end
      end
    end
  end

  assign stat_branches   = r_stat_branches;
  assign stat_mispredict = r_stat_mispredict;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: behavioural table model checked every cycle,
// plus hand-computed literal checks along the test-plan sequence.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredict;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: one record per table slot, counters as plain integers 0..3.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  int          m_cnt    [64];
  logic [31:0] m_target [64];
  logic [31:0] m_branches;
  logic [31:0] m_mispred;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredict(stat_mispredict)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> 8);
  endfunction

  task automatic model_step();
    int s;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin m_valid[i] = 1'b0; m_cnt[i] = 0; end
      m_branches = 0;
      m_mispred  = 0;
    end else begin
      if (upd_valid) begin
        m_branches = m_branches + 1;
        if (upd_pred_taken != upd_taken) m_mispred = m_mispred + 1;
      end
      s = slot_of(upd_pc);
      if (flush) begin
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      end else if (upd_valid) begin
        if (m_valid[s] && m_tag[s] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
            m_target[s] = upd_target;
          end else begin
            m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
          end
        end else if (upd_taken) begin
          m_valid[s]  = 1'b1;
          m_tag[s]    = tag_of(upd_pc);
          m_cnt[s]    = 2;
          m_target[s] = upd_target;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      int s;
      bit exp_t;
      logic [31:0] exp_tgt;
      s = slot_of(if_pc);
      exp_t = m_valid[s] && (m_tag[s] == tag_of(if_pc)) && (m_cnt[s] >= 2);
      exp_tgt = exp_t ? m_target[s] : 32'h0;
      n_vec++;
      if (pred_taken !== exp_t) begin
        n_err++;
        $display("FAIL model_pred_taken pc=%h got=%b exp=%b t=%0t", if_pc, pred_taken, exp_t, $time);
      end
      n_vec++;
      if (pred_target !== exp_tgt) begin
        n_err++;
        $display("FAIL model_pred_target pc=%h got=%h exp=%h t=%0t", if_pc, pred_target, exp_tgt, $time);
      end
      n_vec++;
      if (stat_branches !== m_branches) begin
        n_err++;
        $display("FAIL model_stat_branches got=%0d exp=%0d t=%0t", stat_branches, m_branches, $time);
      end
      n_vec++;
      if (stat_mispredict !== m_mispred) begin
        n_err++;
        $display("FAIL model_stat_mispredict got=%0d exp=%0d t=%0t", stat_mispredict, m_mispred, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic p);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_pred_taken = p;
    tick();
    upd_valid = 1'b0;
  endtask

  logic [31:0] pc_set [8];

  initial begin
    pc_set[0] = 32'h0000_1000; pc_set[1] = 32'h0000_1100; pc_set[2] = 32'h0000_2004;
    pc_set[3] = 32'h0000_1003; pc_set[4] = 32'h0001_2008; pc_set[5] = 32'h0000_20FC;
    pc_set[6] = 32'h0000_3000; pc_set[7] = 32'h0000_21FC;

    rst = 1'b1; flush = 1'b0; if_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    look(32'h0000_1000);
    chk("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("reset_pred_target", pred_target, 32'h0);
    chk("reset_stat_branches", stat_branches, 32'd0);
    chk("reset_stat_mispredict", stat_mispredict, 32'd0);

    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    chk("alloc_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target, 32'h2000);
    chk("alloc_stat_branches", stat_branches, 32'd1);
    chk("alloc_stat_mispredict", stat_mispredict, 32'd1);

    upd(32'h1000, 1'b1, 32'h2000, 1'b1);
    upd(32'h1000, 1'b1, 32'h2000, 1'b1);
    chk("sat_11_taken", {31'b0, pred_taken}, 32'd1);
    upd(32'h1000, 1'b0, 32'h0, 1'b1);
    chk("sat_10_taken", {31'b0, pred_taken}, 32'd1);
    upd(32'h1000, 1'b0, 32'h0, 1'b1);
    chk("sat_01_not_taken", {31'b0, pred_taken}, 32'd0);
    chk("sat_01_target_zero", pred_target, 32'h0);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    upd(32'h1000, 1'b0, 32'h0, 1'b0);
    upd(32'h1000, 1'b1, 32'h2000, 1'b0);
    chk("sat_00_then_taken", {31'b0, pred_taken}, 32'd0);
    chk("sat_stat_branches", stat_branches, 32'd8);
    chk("sat_stat_mispredict", stat_mispredict, 32'd4);

    upd(32'h1100, 1'b1, 32'h5000, 1'b0);
    look(32'h1000);
    chk("alias_old_miss", {31'b0, pred_taken}, 32'd0);
    look(32'h1100);
    chk("alias_new_hit", {31'b0, pred_taken}, 32'd1);
    chk("alias_new_target", pred_target, 32'h5000);

    look(32'h3000);
    upd_valid = 1'b1; upd_pc = 32'h3000; upd_taken = 1'b1; upd_target = 32'h3100; upd_pred_taken = 1'b0;
    #1;
    chk("hazard_same_cycle", {31'b0, pred_taken}, 32'd0);
    tick();
    upd_valid = 1'b0;
    chk("hazard_next_cycle", {31'b0, pred_taken}, 32'd1);
    chk("hazard_next_target", pred_target, 32'h3100);

    flush = 1'b1;
    upd(32'h4000, 1'b1, 32'h4400, 1'b1);
    flush = 1'b0;
    look(32'h4000);
    chk("flush_drops_write", {31'b0, pred_taken}, 32'd0);
    look(32'h1100);
    chk("flush_clears_valid", {31'b0, pred_taken}, 32'd0);
    chk("flush_stat_branches", stat_branches, 32'd11);

    upd(32'h1100, 1'b1, 32'h5500, 1'b0);
    chk("realloc_after_flush", {31'b0, pred_taken}, 32'd1);

    rst = 1'b1;
    upd(32'h6000, 1'b1, 32'h6600, 1'b0);
    rst = 1'b0;
    chk("rst_stat_branches", stat_branches, 32'd0);
    chk("rst_stat_mispredict", stat_mispredict, 32'd0);
    chk("rst_old_entry", {31'b0, pred_taken}, 32'd0);
    look(32'h6000);
    chk("rst_drops_update", {31'b0, pred_taken}, 32'd0);

    // Mixed traffic over a small PC set with aliasing slots, checked by the model each cycle.
    for (int i = 0; i < 120; i++) begin
      if_pc          = pc_set[$urandom_range(0, 7)];
      upd_valid      = ($urandom_range(0, 3) != 0);
      upd_pc         = pc_set[$urandom_range(0, 7)];
      upd_taken      = ($urandom_range(0, 2) != 0);
      upd_target     = $urandom;
      upd_pred_taken = $urandom_range(0, 1) == 1;
      flush          = ($urandom_range(0, 29) == 0);
      tick();
    end
    upd_valid = 1'b0; flush = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Direct-mapped branch history table with branch target buffer, sitting in the IF stage.
- Predicts the outcome that the EX-stage branch comparator later resolves; EX feeds the resolved outcome back through the update port.
- Each entry holds: valid bit, tag, 2-bit saturating counter, 32-bit target.
- Also keeps performance counters for resolved branches and mispredicts.

Parameters:
- IDX_W, 6, index width; ENTRIES = 2^IDX_W.
- TAG_W, 24, tag width; must equal 30-IDX_W (tag = pc[31:IDX_W+2]).
- CNT_INIT, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- if_pc  input  32  IF-stage fetch PC.
- pred_taken  output  1  predicted taken for if_pc.
- pred_target  output  32  predicted target for if_pc; 0 when pred_taken=0.
- upd_valid  input  1  EX resolved a conditional branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved outcome (comparator result).
- upd_target  input  32  resolved branch target.
- upd_pred_taken  input  1  prediction that was made for this branch, carried down the pipe.
- flush  input  1  invalidate the whole table (e.g. fence.i).
- stat_branches  output  32  count of upd_valid cycles.
- stat_mispredict  output  32  count of upd_valid cycles with upd_pred_taken != upd_taken.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Lookup is combinational, zero latency.
  - hit = valid[idx] & (tag[idx] == if_tag).
  - pred_taken = hit & cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : 32'h0.
- Update takes effect at the rising edge when upd_valid=1.
  - Hit, taken: cnt saturating increment (3 stays 3); target <= upd_target.
  - Hit, not taken: cnt saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=upd tag, cnt<=CNT_INIT, target<=upd_target. The old entry is overwritten.
  - Miss, not taken: table unchanged.
- Same-cycle read/write hazard: a lookup at the index being updated returns pre-update contents. No bypass.
- Counter transitions: 00<->01<->10<->11, one step per update. Bit 1 gives the prediction.
- Statistics:
  - stat_branches += 1 on every upd_valid.
  - stat_mispredict += 1 when upd_valid & (upd_pred_taken ^ upd_taken).
  - Both wrap modulo 2^32.
- Reset (rst=1 at edge):
  - All valid bits <= 0, all cnt <= 2'b00, both stat counters <= 0.
  - tag/target contents are don't-care.
  - From the cycle after reset: pred_taken=0, pred_target=0.
  - rst has priority over flush and upd_valid.
- Flush (flush=1, rst=0):
  - All valid bits <= 0; counters and stats untouched.
  - A simultaneous upd_valid table write is dropped, but the stats still count it.
- Reset mid-operation: any in-flight update on the reset edge is discarded. No multi-cycle state exists, so no recovery sequence is required.
- No X on outputs after the first reset edge.

Test Plan:
- Reset, then if_pc=0x0000_1000 -> pred_taken=0, pred_target=0, stat_branches=0, stat_mispredict=0.
- Update pc=0x1000, taken=1, target=0x2000, pred=0; next cycle if_pc=0x1000 -> pred_taken=1, pred_target=0x2000, stat_branches=1, stat_mispredict=1.
- Saturation at pc=0x1000 after allocation (cnt=10):
  - Two taken updates -> cnt=11, still taken.
  - Then one not-taken -> cnt=10, pred_taken=1.
  - Then second not-taken -> cnt=01, pred_taken=0.
  - Then two more not-taken -> cnt=00; a following taken -> cnt=01, pred_taken=0.
- Aliasing: allocate 0x1000, then taken update at 0x1100 (same index, IDX_W=6, different tag).
  - if_pc=0x1000 -> miss, pred_taken=0.
  - if_pc=0x1100 -> hit with the new target.
- Same-cycle hazard: if_pc=upd_pc=0x3000 allocating -> pred_taken=0 that cycle, 1 the next cycle.
- Priority checks:
  - flush=1 with upd_valid taken at 0x4000 -> no entry afterwards, stat_branches increments.
  - rst=1 with upd_valid -> all stats 0, table empty.
